// File: rtl/sd_sector_sequencer.sv
// Single-sector transfer sequencer between the CPU side and the byte-wide SD SPI controller.
// Each transfer moves SECTOR_BYTES bytes between the controller and a 512x8 sector buffer, and every wait state is guarded by a watchdog.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start
// S_WAIT_RDY | waiting for the controller to be ready for a command
// S_ISSUE    | holding sd_rd/sd_wr until the controller drops sd_ready
// S_RD_DATA  | writing controller bytes into the buffer
// S_WR_PRE   | priming sd_din with buffer byte 0, prefetching byte 1
// S_WR_DATA  | feeding buffer bytes to the controller
// S_FINISH   | waiting for the controller to finish the CRC/busy phase
module sd_sector_sequencer #(
   parameter int BYTE_ADDRESSING = 1,
   parameter int TIMEOUT_CYCLES  = 5000000,
   parameter int SECTOR_BYTES    = 512
) (
   input  logic        iCLK,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rw,
   input  logic [31:0] sector,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        sd_ready,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_address,
   input  logic [7:0]  sd_dout,
   input  logic        sd_byte_available,
   output logic [7:0]  sd_din,
   input  logic        sd_ready_for_next_byte,
   output logic [8:0]  buf_addr,
   output logic [7:0]  buf_wdata,
   output logic        buf_we,
   input  logic [7:0]  buf_rdata
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [9:0]    C_LAST = 10'(SECTOR_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_RDY, S_ISSUE, S_RD_DATA, S_WR_PRE, S_WR_DATA, S_FINISH
   } state_t;

   state_t        state, state_nx;
   logic          rw_q, rw_nx;
   logic          busy_nx, done_nx, error_nx, rd_nx, wr_nx, we_nx;
   logic [31:0]   addr_nx;
   logic [7:0]    din_nx, wdata_nx;
   logic [8:0]    baddr_nx;
   logic [9:0]    count, count_nx;
   logic [TW-1:0] tcount, tcount_nx;
   logic          avail_q, rfnb_q;
   logic          pre_wait, pre_nx;
   logic          reload, reload_nx;
   logic          avail_rise, rfnb_rise;
   logic          counting, timed_out, byte_evt;

   assign avail_rise = sd_byte_available & ~avail_q;
   assign rfnb_rise  = sd_ready_for_next_byte & ~rfnb_q;
   assign counting   = (state == S_WAIT_RDY) || (state == S_ISSUE) ||
                       (state == S_RD_DATA) || (state == S_WR_DATA) ||
                       (state == S_FINISH);
   assign timed_out  = counting && (tcount == T_LAST);

   always_comb begin
      state_nx  = state;
      rw_nx     = rw_q;
      busy_nx   = busy;
      done_nx   = 1'b0;
      error_nx  = error;
      rd_nx     = sd_rd;
      wr_nx     = sd_wr;
      addr_nx   = sd_address;
      din_nx    = sd_din;
      baddr_nx  = buf_addr;
      wdata_nx  = buf_wdata;
      we_nx     = 1'b0;
      count_nx  = count;
      pre_nx    = pre_wait;
      reload_nx = 1'b0;
      byte_evt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               rw_nx    = rw;
               addr_nx  = (BYTE_ADDRESSING != 0) ? {sector[22:0], 9'b0} : sector;
               error_nx = 1'b0;
               busy_nx  = 1'b1;
               count_nx = '0;
               state_nx = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (sd_ready) begin
               rd_nx    = ~rw_q;
               wr_nx    = rw_q;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!sd_ready) begin
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               count_nx = '0;
               if (rw_q) begin
                  baddr_nx = '0;
                  pre_nx   = 1'b0;
                  state_nx = S_WR_PRE;
               end else begin
                  state_nx = S_RD_DATA;
               end
            end
         end
         S_RD_DATA: begin
            if (avail_rise) begin
               byte_evt = 1'b1;
               we_nx    = 1'b1;
               baddr_nx = count[8:0];
               wdata_nx = sd_dout;
               count_nx = count + 10'd1;
               if (count == C_LAST) state_nx = S_FINISH;
            end
         end
         // Address 0 was presented on entry; buffer data is valid one cycle later.
         S_WR_PRE: begin
            if (!pre_wait) begin
               pre_nx = 1'b1;
            end else begin
               din_nx   = buf_rdata;
               baddr_nx = 9'd1;
               state_nx = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            if (reload) begin
               din_nx   = buf_rdata;
               baddr_nx = buf_addr + 9'd1;
            end
            if (rfnb_rise) begin
               byte_evt  = 1'b1;
               reload_nx = 1'b1;
               count_nx  = count + 10'd1;
               if (count == C_LAST) state_nx = S_FINISH;
            end
         end
         S_FINISH: begin
            if (sd_ready) begin
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (timed_out) begin
         state_nx  = S_IDLE;
         error_nx  = 1'b1;
         busy_nx   = 1'b0;
         done_nx   = 1'b0;
         rd_nx     = 1'b0;
         wr_nx     = 1'b0;
         we_nx     = 1'b0;
         reload_nx = 1'b0;
      end
      if ((state_nx != state) || byte_evt || !counting) tcount_nx = '0;
      else                                              tcount_nx = tcount + 1'b1;
   end

   always_ff @(posedge iCLK) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         rw_q       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         sd_address <= '0;
         sd_din     <= '0;
         buf_addr   <= '0;
         buf_wdata  <= '0;
         buf_we     <= 1'b0;
         count      <= '0;
         tcount     <= '0;
         avail_q    <= 1'b0;
         rfnb_q     <= 1'b0;
         pre_wait   <= 1'b0;
         reload     <= 1'b0;
      end else begin
         state      <= state_nx;
         rw_q       <= rw_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         error      <= error_nx;
         sd_rd      <= rd_nx;
         sd_wr      <= wr_nx;
         sd_address <= addr_nx;
         sd_din     <= din_nx;
         buf_addr   <= baddr_nx;
         buf_wdata  <= wdata_nx;
         buf_we     <= we_nx;
         count      <= count_nx;
         tcount     <= tcount_nx;
         avail_q    <= sd_byte_available;
         rfnb_q     <= sd_ready_for_next_byte;
         pre_wait   <= pre_nx;
         reload     <= reload_nx;
      end
   end

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Directed bench: SDSC/SDHC reads, write streaming, watchdog timeout, ignored start, wide strobe, mid-transfer reset.
module tb_sd_sector_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start_a, start_b, rw, sd_ready, byte_avail, rfnb;
   logic [31:0] sector;
   logic [7:0]  sd_dout, buf_rdata;

   logic        busy_a, done_a, error_a, sd_rd_a, sd_wr_a, bwe_a;
   logic [31:0] addr_a;
   logic [7:0]  din_a, bwdata_a;
   logic [8:0]  baddr_a;

   logic        busy_b, done_b, error_b, sd_rd_b, sd_wr_b, bwe_b;
   logic [31:0] addr_b;
   logic [7:0]  din_b, bwdata_b;
   logic [8:0]  baddr_b;

   sd_sector_sequencer #(.BYTE_ADDRESSING(1), .TIMEOUT_CYCLES(100), .SECTOR_BYTES(512)) dut_a (
      .iCLK(clk), .reset_n(reset_n), .start(start_a), .rw(rw), .sector(sector),
      .busy(busy_a), .done(done_a), .error(error_a), .sd_ready(sd_ready),
      .sd_rd(sd_rd_a), .sd_wr(sd_wr_a), .sd_address(addr_a), .sd_dout(sd_dout),
      .sd_byte_available(byte_avail), .sd_din(din_a), .sd_ready_for_next_byte(rfnb),
      .buf_addr(baddr_a), .buf_wdata(bwdata_a), .buf_we(bwe_a), .buf_rdata(buf_rdata));

   sd_sector_sequencer #(.BYTE_ADDRESSING(0), .TIMEOUT_CYCLES(100), .SECTOR_BYTES(512)) dut_b (
      .iCLK(clk), .reset_n(reset_n), .start(start_b), .rw(rw), .sector(sector),
      .busy(busy_b), .done(done_b), .error(error_b), .sd_ready(sd_ready),
      .sd_rd(sd_rd_b), .sd_wr(sd_wr_b), .sd_address(addr_b), .sd_dout(sd_dout),
      .sd_byte_available(byte_avail), .sd_din(din_b), .sd_ready_for_next_byte(rfnb),
      .buf_addr(baddr_b), .buf_wdata(bwdata_b), .buf_we(bwe_b), .buf_rdata(buf_rdata));

   // Sector buffer model; in write-pattern mode it reads back as buf[i] = ~i.
   logic [7:0] mem [512];
   logic       wr_pattern;
   always @(posedge clk) begin
      if (bwe_a) mem[baddr_a] <= bwdata_a;
      buf_rdata <= wr_pattern ? ~baddr_a[7:0] : mem[baddr_a];
   end

   int we_cnt = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (bwe_a)  we_cnt   <= we_cnt + 1;
      if (done_a) done_cnt <= done_cnt + 1;
   end

   int checks = 0;
   int failures = 0;
   logic [7:0] cap_arr [512];

   function automatic logic [7:0] pat_byte(input int pat, input int i);
      return (pat == 0) ? 8'(i) : 8'(i * 3 + 1);
   endfunction

   task automatic pulse_start(input logic which_b, input logic r, input logic [31:0] s);
      @(negedge clk);
      rw = r; sector = s;
      if (which_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic accept_cmd();
      repeat (2) @(negedge clk);
      sd_ready = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input int width);
      sd_dout = d; byte_avail = 1'b1;
      repeat (width) @(negedge clk);
      byte_avail = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic stream_read(input int pat, input int lo, input int hi, input int wide_idx);
      for (int i = lo; i <= hi; i++) send_byte(pat_byte(pat, i), (i == wide_idx) ? 20 : 4);
   endtask

   task automatic stream_write();
      logic [7:0] c;
      for (int k = 0; k < 512; k++) begin
         rfnb = 1'b1; c = din_a;
         repeat (3) @(negedge clk);
         rfnb = 1'b0;
         repeat (2) @(negedge clk);
         cap_arr[k] = c;
      end
   endtask

   task automatic finish_xfer(output bit got);
      repeat (3) @(negedge clk);
      sd_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done_a) got = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_a = 0; start_b = 0; rw = 0; sector = '0; sd_ready = 1'b1;
      sd_dout = '0; byte_avail = 0; rfnb = 0; wr_pattern = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, done_a, error_a, sd_rd_a, sd_wr_a, bwe_a} !== 6'b0) begin
         failures++; $display("FAIL reset_ctl got %b want 000000", {busy_a, done_a, error_a, sd_rd_a, sd_wr_a, bwe_a});
      end
      checks++;
      if (addr_a !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 0", addr_a); end
      checks++;
      if ({din_a, baddr_a} !== 17'h0) begin failures++; $display("FAIL reset_din_baddr got %h/%h want 0/0", din_a, baddr_a); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sdhc();
      bit held = 1'b1;
      pulse_start(1'b1, 1'b0, 32'h12345);
      @(negedge clk);
      checks++;
      if (addr_b !== 32'h0001_2345) begin failures++; $display("FAIL sdhc_addr got %h want 00012345", addr_b); end
      for (int i = 0; i < 4; i++) begin
         if (sd_rd_b !== 1'b1) held = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (held !== 1'b1) begin failures++; $display("FAIL sdhc_rd_hold got %b want 1", held); end
      sd_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({sd_rd_b, busy_b} !== 2'b01) begin failures++; $display("FAIL sdhc_rd_release got %b want 01", {sd_rd_b, busy_b}); end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; sd_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_sdsc();
      int we0, d0, nerr;
      bit got;
      we0 = we_cnt; d0 = done_cnt;
      pulse_start(1'b0, 1'b0, 32'd3);
      checks++;
      if (sd_rd_a !== 1'b0) begin failures++; $display("FAIL rd_latency_early got %b want 0", sd_rd_a); end
      @(negedge clk);
      checks++;
      if ({sd_rd_a, sd_wr_a} !== 2'b10) begin failures++; $display("FAIL rd_cmd got %b want 10", {sd_rd_a, sd_wr_a}); end
      checks++;
      if (addr_a !== 32'h600) begin failures++; $display("FAIL sdsc_addr got %h want 00000600", addr_a); end
      accept_cmd();
      stream_read(0, 0, 511, -1);
      checks++;
      if (busy_a !== 1'b1) begin failures++; $display("FAIL rd_busy_finish got %b want 1", busy_a); end
      finish_xfer(got);
      checks++;
      if (got !== 1'b1) begin failures++; $display("FAIL rd_done_seen got %b want 1", got); end
      checks++;
      if (we_cnt - we0 !== 512) begin failures++; $display("FAIL rd_we_count got %0d want 512", we_cnt - we0); end
      nerr = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== pat_byte(0, i)) nerr++;
      checks++;
      if (nerr !== 0) begin failures++; $display("FAIL rd_data bad_bytes got %0d want 0", nerr); end
      checks++;
      if (done_cnt - d0 !== 1) begin failures++; $display("FAIL rd_done_count got %0d want 1", done_cnt - d0); end
      checks++;
      if ({error_a, busy_a} !== 2'b00) begin failures++; $display("FAIL rd_end_flags got %b want 00", {error_a, busy_a}); end
   endtask

   task automatic test_write(input logic [31:0] sec, input logic [31:0] exp_addr);
      int nerr, d0;
      bit got;
      logic [7:0] e;
      wr_pattern = 1'b1;
      d0 = done_cnt;
      pulse_start(1'b0, 1'b1, sec);
      @(negedge clk);
      checks++;
      if ({sd_rd_a, sd_wr_a} !== 2'b01) begin failures++; $display("FAIL wr_cmd got %b want 01", {sd_rd_a, sd_wr_a}); end
      checks++;
      if (addr_a !== exp_addr) begin failures++; $display("FAIL wr_addr got %h want %h", addr_a, exp_addr); end
      accept_cmd();
      stream_write();
      finish_xfer(got);
      nerr = 0;
      for (int k = 0; k < 512; k++) begin
         e = 8'(k); e = ~e;
         if (cap_arr[k] !== e) begin
            if (nerr == 0) $display("FAIL wr_byte idx %0d got %h want %h", k, cap_arr[k], e);
            nerr++;
         end
      end
      checks++;
      if (nerr !== 0) begin failures++; $display("FAIL wr_data bad_bytes got %0d want 0", nerr); end
      checks++;
      if (got !== 1'b1 || done_cnt - d0 !== 1) begin
         failures++; $display("FAIL wr_done got seen=%b count=%0d want 1/1", got, done_cnt - d0);
      end
      wr_pattern = 1'b0;
   endtask

   task automatic test_timeout();
      int we0, d0;
      bit got;
      we0 = we_cnt; d0 = done_cnt;
      pulse_start(1'b0, 1'b0, 32'd5);
      @(negedge clk);
      accept_cmd();
      stream_read(0, 0, 9, -1);
      sd_dout = 8'd10; byte_avail = 1'b1;
      repeat (4) @(negedge clk);
      byte_avail = 1'b0;
      repeat (96) @(negedge clk);
      checks++;
      if ({error_a, busy_a} !== 2'b01) begin failures++; $display("FAIL to_before got %b want 01", {error_a, busy_a}); end
      @(negedge clk);
      checks++;
      if ({error_a, busy_a, sd_rd_a, bwe_a} !== 4'b1000) begin
         failures++; $display("FAIL to_fire got %b want 1000", {error_a, busy_a, sd_rd_a, bwe_a});
      end
      @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 0 || we_cnt - we0 !== 11) begin
         failures++; $display("FAIL to_counts got done=%0d we=%0d want 0/11", done_cnt - d0, we_cnt - we0);
      end
      sd_ready = 1'b1;
      we0 = we_cnt; d0 = done_cnt;
      pulse_start(1'b0, 1'b0, 32'd1);
      checks++;
      if ({error_a, busy_a} !== 2'b01) begin failures++; $display("FAIL to_restart got %b want 01", {error_a, busy_a}); end
      @(negedge clk);
      accept_cmd();
      stream_read(0, 0, 511, -1);
      finish_xfer(got);
      checks++;
      if (got !== 1'b1 || error_a !== 1'b0 || done_cnt - d0 !== 1 || we_cnt - we0 !== 512) begin
         failures++; $display("FAIL to_recover got done=%b err=%b dcnt=%0d we=%0d want 1/0/1/512", got, error_a, done_cnt - d0, we_cnt - we0);
      end
   endtask

   task automatic test_robust();
      int we0, d0, nerr;
      bit got;
      we0 = we_cnt; d0 = done_cnt;
      pulse_start(1'b0, 1'b0, 32'd7);
      @(negedge clk);
      accept_cmd();
      stream_read(1, 0, 99, 50);
      rw = 1'b1; sector = 32'd99; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      checks++;
      if (addr_a !== 32'hE00 || busy_a !== 1'b1 || sd_wr_a !== 1'b0) begin
         failures++; $display("FAIL rb_ignore_start got addr=%h busy=%b wr=%b want 00000e00/1/0", addr_a, busy_a, sd_wr_a);
      end
      stream_read(1, 100, 511, -1);
      finish_xfer(got);
      checks++;
      if (we_cnt - we0 !== 512) begin failures++; $display("FAIL rb_we_count got %0d want 512", we_cnt - we0); end
      nerr = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== pat_byte(1, i)) nerr++;
      checks++;
      if (nerr !== 0) begin failures++; $display("FAIL rb_data bad_bytes got %0d want 0", nerr); end
      checks++;
      if (got !== 1'b1 || done_cnt - d0 !== 1) begin failures++; $display("FAIL rb_done got %b/%0d want 1/1", got, done_cnt - d0); end
   endtask

   task automatic test_reset_midread();
      int d0;
      pulse_start(1'b0, 1'b0, 32'd2);
      @(negedge clk);
      accept_cmd();
      stream_read(0, 0, 199, -1);
      sd_dout = 8'd200; byte_avail = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++;
      if ({busy_a, done_a, error_a, sd_rd_a, sd_wr_a, bwe_a} !== 6'b0) begin
         failures++; $display("FAIL mr_ctl got %b want 000000", {busy_a, done_a, error_a, sd_rd_a, sd_wr_a, bwe_a});
      end
      checks++;
      if (addr_a !== 32'h0 || baddr_a !== 9'h0 || din_a !== 8'h0) begin
         failures++; $display("FAIL mr_regs got addr=%h baddr=%h din=%h want 0/0/0", addr_a, baddr_a, din_a);
      end
      byte_avail = 1'b0; sd_ready = 1'b1;
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 0 || busy_a !== 1'b0) begin
         failures++; $display("FAIL mr_quiet got done=%0d busy=%b want 0/0", done_cnt - d0, busy_a);
      end
      test_write(32'd4, 32'h800);
   endtask

   initial begin
      test_reset();
      test_sdhc();
      test_read_sdsc();
      test_write(32'd8, 32'h1000);
      test_timeout();
      test_robust();
      test_reset_midread();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
